// File: rtl/aemb_dma_pkg.sv
// aemb_dma_pkg
// Shared definitions for the aeMB Wishbone DMA engine: FSM state encoding
// and the full-word byte-lane select.
package aemb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RGAP = 3'd2,
    ST_WR   = 3'd3,
    ST_WGAP = 3'd4
  } dma_state_e;

  localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/aemb_dma_cnt.sv
// aemb_dma_cnt
// Source, destination and length registers of the DMA engine. Addresses are
// held as word addresses so the low byte-address bits are zero by
// construction and the +4 step wraps modulo 2^DSIZ for free.
// Ports:
//   sys_clk_i, sys_rst_i  clock, synchronous active-high reset
//   load                  capture src_in/dst_in/len_in
//   adv                   src+=4, dst+=4, len-=1
//   src_in, dst_in        byte addresses (bits [1:0] dropped)
//   len_in                word count
//   src, dst              current word-aligned byte addresses
//   len_zero              remaining word count is zero
module aemb_dma_cnt #(
  parameter int DSIZ = 16
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            load,
  input  logic            adv,
  input  logic [DSIZ-1:0] src_in,
  input  logic [DSIZ-1:0] dst_in,
  input  logic [DSIZ-3:0] len_in,
  output logic [DSIZ-1:0] src,
  output logic [DSIZ-1:0] dst,
  output logic            len_zero
);

  localparam logic [DSIZ-3:0] ONE = {{(DSIZ-3){1'b0}}, 1'b1};

  logic [DSIZ-3:0] src_w;
  logic [DSIZ-3:0] dst_w;
  logic [DSIZ-3:0] len_q;

  // Byte-offset bits of the configured addresses are intentionally dropped.
  logic unused_lsb;
  assign unused_lsb = ^{src_in[1:0], dst_in[1:0]};

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      src_w <= '0;
      dst_w <= '0;
      len_q <= '0;
    end else if (load) begin
      src_w <= src_in[DSIZ-1:2];
      dst_w <= dst_in[DSIZ-1:2];
      len_q <= len_in;
    end else if (adv) begin
      src_w <= src_w + ONE;
      dst_w <= dst_w + ONE;
      len_q <= len_q - ONE;
    end
  end

  assign src      = {src_w, 2'b00};
  assign dst      = {dst_w, 2'b00};
  assign len_zero = (len_q == '0);

endmodule

// File: rtl/aemb_wb_dma.sv
// aemb_wb_dma
// Word-granularity Wishbone initiator on the aeMB data bus. Copies len
// 32-bit words from src to dst, one read and one write per word, each bus
// phase followed by a one-cycle idle gap so stale registered acks are
// harmlessly dropped.
// Optional build macro: AEMB_DMA_FILL_EN adds fill mode (cfg_fill_i=1 writes
// cfg_pat_i to every destination word, no reads). Without it cfg_fill_i and
// cfg_pat_i are ignored.
// Ports:
//   sys_clk_i, sys_rst_i      clock, synchronous active-high reset
//   cfg_start_i               start strobe (ignored while busy)
//   cfg_src_i/dst_i/len_i     descriptor
//   cfg_fill_i, cfg_pat_i     fill select and pattern
//   dwb_*                     Wishbone data bus (initiator side)
//   busy_o, done_o            status; done_o pulses one cycle on completion
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for cfg_start_i
// RD      | read cycle at src, waiting for ack
// RGAP    | one idle cycle after read
// WR      | write cycle at dst, waiting for ack
// WGAP    | one idle cycle after write; decide next word/done
module aemb_wb_dma
  import aemb_dma_pkg::*;
#(
  parameter int DSIZ = 16
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic            cfg_start_i,
  input  logic [DSIZ-1:0] cfg_src_i,
  input  logic [DSIZ-1:0] cfg_dst_i,
  input  logic [DSIZ-3:0] cfg_len_i,
  input  logic            cfg_fill_i,
  input  logic [31:0]     cfg_pat_i,
  output logic [DSIZ-1:0] dwb_adr_o,
  output logic [31:0]     dwb_dat_o,
  input  logic [31:0]     dwb_dat_i,
  output logic            dwb_we_o,
  output logic            dwb_stb_o,
  output logic [3:0]      dwb_sel_o,
  input  logic            dwb_ack_i,
  output logic            busy_o,
  output logic            done_o
);

  dma_state_e      state_q, state_d;
  logic            done_q, done_d;
  logic [31:0]     data_q;
  logic            load, adv, len_zero, fill_w;
  logic [DSIZ-1:0] src, dst;

  assign load = (state_q == ST_IDLE) && cfg_start_i;
  assign adv  = (state_q == ST_WR) && dwb_ack_i;

  aemb_dma_cnt #(.DSIZ(DSIZ)) u_cnt (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .load      (load),
    .adv       (adv),
    .src_in    (cfg_src_i),
    .dst_in    (cfg_dst_i),
    .len_in    (cfg_len_i),
    .src       (src),
    .dst       (dst),
    .len_zero  (len_zero)
  );

`ifdef AEMB_DMA_FILL_EN
  logic fill_q;
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)
      fill_q <= 1'b0;
    else if (load)
      fill_q <= cfg_fill_i;
  end
  assign fill_w = fill_q;
`else
  logic unused_fill;
  assign unused_fill = ^{cfg_fill_i, cfg_pat_i};
  assign fill_w = 1'b0;
`endif

  // Data register doubles as the fill pattern holder: in fill mode no read
  // ever overwrites it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)
      data_q <= '0;
    else if ((state_q == ST_RD) && dwb_ack_i)
      data_q <= dwb_dat_i;
`ifdef AEMB_DMA_FILL_EN
    else if (load && cfg_fill_i)
      data_q <= cfg_pat_i;
`endif
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          if (cfg_len_i == '0)
            done_d = 1'b1;
`ifdef AEMB_DMA_FILL_EN
          else if (cfg_fill_i)
            state_d = ST_WR;
`endif
          else
            state_d = ST_RD;
        end
      end
      ST_RD:   if (dwb_ack_i) state_d = ST_RGAP;
      ST_RGAP: state_d = ST_WR;
      ST_WR:   if (dwb_ack_i) state_d = ST_WGAP;
      ST_WGAP: begin
        if (len_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (fill_w) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and data are zeroed outside a strobed cycle so the bus is
  // quiet when idle and after reset.
  always_comb begin
    dwb_stb_o = 1'b0;
    dwb_we_o  = 1'b0;
    dwb_adr_o = '0;
    dwb_dat_o = '0;
    case (state_q)
      ST_RD: begin
        dwb_stb_o = 1'b1;
        dwb_adr_o = src;
      end
      ST_WR: begin
        dwb_stb_o = 1'b1;
        dwb_we_o  = 1'b1;
        dwb_adr_o = dst;
        dwb_dat_o = data_q;
      end
      default: ;
    endcase
    dwb_sel_o = dwb_stb_o ? SEL_WORD : 4'h0;
    busy_o    = (state_q != ST_IDLE);
    done_o    = done_q;
  end

endmodule

// File: tb/tb_aemb_wb_dma.sv
// tb_aemb_wb_dma
// Directed bench for aemb_wb_dma (DSIZ=16) on a RAM slave whose ack is a
// registered copy of stb, optionally delayed by wait_n cycles.
module tb_aemb_wb_dma;
  localparam int DSIZ = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [15:0]     cfg_src, cfg_dst;
  logic [13:0]     cfg_len;
  logic            cfg_fill;
  logic [31:0]     cfg_pat;
  logic [15:0]     adr;
  logic [31:0]     dat_o, dat_i;
  logic            we, stb, ack, busy, done;
  logic [3:0]      sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aemb_wb_dma #(.DSIZ(DSIZ)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .cfg_start_i (cfg_start),
    .cfg_src_i   (cfg_src),
    .cfg_dst_i   (cfg_dst),
    .cfg_len_i   (cfg_len),
    .cfg_fill_i  (cfg_fill),
    .cfg_pat_i   (cfg_pat),
    .dwb_adr_o   (adr),
    .dwb_dat_o   (dat_o),
    .dwb_dat_i   (dat_i),
    .dwb_we_o    (we),
    .dwb_stb_o   (stb),
    .dwb_sel_o   (sel),
    .dwb_ack_i   (ack),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Slave RAM and bus monitor
  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [15:0] pl_adr = '0;
  logic [31:0] pl_dat = '0;
  int          wait_n = 0;
  int          ws_cnt = 0;
  int          wr_cnt = 0, sel_err = 0, stab_err = 0, stb_seen = 0, done_cnt = 0;
  logic [15:0] rd_q [$];
  logic        prev_wait = 1'b0;
  logic [15:0] prev_adr = '0;
  logic        prev_we = 1'b0;

  assign dat_i = mem[adr[15:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_adr[15:2]] <= pl_dat;
    if (rst) begin
      ack       <= 1'b0;
      ws_cnt    <= 0;
      prev_wait <= 1'b0;
    end else begin
      ack    <= stb && (ws_cnt >= wait_n);
      ws_cnt <= stb ? ws_cnt + 1 : 0;
      if (stb && ack && we) begin
        mem[adr[15:2]] <= dat_o;
        wr_cnt <= wr_cnt + 1;
      end
      if (stb && ack && !we) rd_q.push_back(adr);
      if (stb) stb_seen <= stb_seen + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (stb ? (sel !== 4'hF) : (sel !== 4'h0)) sel_err <= sel_err + 1;
      if (prev_wait && (!stb || adr !== prev_adr || we !== prev_we)) stab_err <= stab_err + 1;
      prev_wait <= stb && !ack;
      prev_adr  <= adr;
      prev_we   <= we;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_adr = a; pl_dat = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Start a transfer and wait for done; optionally inject an extra start
  // (with different descriptor) at cycle inj while busy. lat=-1 on timeout.
  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [13:0] l,
                     input logic f, input logic [31:0] p, input int inj,
                     output int lat, output logic busy1, output logic stb1,
                     output logic [15:0] adr1);
    int cyc;
    @(posedge clk); #1;
    cfg_src = s; cfg_dst = d; cfg_len = l; cfg_fill = f; cfg_pat = p; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    busy1 = busy; stb1 = stb; adr1 = adr;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == inj) begin
        cfg_src = 16'h0900; cfg_dst = 16'h0A00; cfg_len = 14'd7; cfg_fill = ~f;
        cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    cfg_start = 1'b0;
    lat = done ? cyc : -1;
  endtask

  int          lat, base_rd, base_wr, base_stb, base_done, cyc;
  logic        b1, s1;
  logic [15:0] a1;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    cfg_fill = 1'b0; cfg_pat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stb", {31'b0, stb}, 0);
    check("rst_we", {31'b0, we}, 0);
    check("rst_sel", {28'b0, sel}, 0);
    check("rst_adr", {16'b0, adr}, 0);
    check("rst_dat", dat_o, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    rst = 1'b0;

    // Copy, registered ack
    poke(16'h0100, 32'h11111111); poke(16'h0104, 32'h22222222);
    poke(16'h0108, 32'h33333333); poke(16'h010C, 32'h44444444);
    run(16'h0100, 16'h0200, 14'd4, 1'b0, 32'h0, 0, lat, b1, s1, a1);
    check("copy_busy1", {31'b0, b1}, 1);
    check("copy_stb1", {31'b0, s1}, 1);
    check("copy_adr1", {16'b0, a1}, 32'h0100);
    check("copy_latency", lat, 25);
    check("copy_busy_at_done", {31'b0, busy}, 0);
    @(posedge clk); #1;
    check("copy_done_pulse", {31'b0, done}, 0);
    check("copy_m0", mem[16'h0200 >> 2], 32'h11111111);
    check("copy_m1", mem[16'h0204 >> 2], 32'h22222222);
    check("copy_m2", mem[16'h0208 >> 2], 32'h33333333);
    check("copy_m3", mem[16'h020C >> 2], 32'h44444444);

    // len = 0
    base_stb = stb_seen;
    run(16'h0100, 16'h0700, 14'd0, 1'b0, 32'h0, 0, lat, b1, s1, a1);
    check("len0_latency", lat, 1);
    @(posedge clk); #1;
    check("len0_done_pulse", {31'b0, done}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_stb", stb_seen, base_stb);

    // Wrap-around
    poke(16'hFFF8, 32'hA0A0A0A0); poke(16'hFFFC, 32'hA1A1A1A1);
    poke(16'h0000, 32'hA2A2A2A2); poke(16'h0004, 32'hA3A3A3A3);
    base_rd = rd_q.size();
    run(16'hFFF8, 16'h0600, 14'd4, 1'b0, 32'h0, 0, lat, b1, s1, a1);
    check("wrap_latency", lat, 25);
    check("wrap_nrd", rd_q.size() - base_rd, 4);
    if (rd_q.size() - base_rd == 4) begin
      check("wrap_rd0", {16'b0, rd_q[base_rd]}, 32'hFFF8);
      check("wrap_rd1", {16'b0, rd_q[base_rd+1]}, 32'hFFFC);
      check("wrap_rd2", {16'b0, rd_q[base_rd+2]}, 32'h0000);
      check("wrap_rd3", {16'b0, rd_q[base_rd+3]}, 32'h0004);
    end
    check("wrap_m2", mem[16'h0608 >> 2], 32'hA2A2A2A2);
    check("wrap_m3", mem[16'h060C >> 2], 32'hA3A3A3A3);

    // Wait-state slave, with a start pulse while busy
    poke(16'h0700, 32'hCAFE0001); poke(16'h0704, 32'hCAFE0002);
    poke(16'h0A00, 32'h5A5A5A5A);
    wait_n = 3;
    run(16'h0700, 16'h0800, 14'd2, 1'b0, 32'h0, 4, lat, b1, s1, a1);
    check("ws_latency", lat, 25);
    check("ws_m0", mem[16'h0800 >> 2], 32'hCAFE0001);
    check("ws_m1", mem[16'h0804 >> 2], 32'hCAFE0002);
    check("ws_ignored_start", mem[16'h0A00 >> 2], 32'h5A5A5A5A);
    wait_n = 0;
    repeat (4) @(posedge clk);
    #1;
    check("ws_idle_after", {31'b0, busy}, 0);

    // Reset during the 2nd WR of a len=5 copy
    poke(16'h0400, 32'hB0000000); poke(16'h0404, 32'hB0000001);
    poke(16'h0408, 32'hB0000002); poke(16'h040C, 32'hB0000003);
    poke(16'h0410, 32'hB0000004);
    base_wr = wr_cnt;
    @(posedge clk); #1;
    cfg_src = 16'h0400; cfg_dst = 16'h0500; cfg_len = 14'd5; cfg_fill = 1'b0; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cyc = 0;
    while (!(stb && we && wr_cnt - base_wr == 1) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_wr2", {31'b0, (cyc < 100)}, 1);
    base_done = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_stb", {31'b0, stb}, 0);
    check("abort_we", {31'b0, we}, 0);
    check("abort_sel", {28'b0, sel}, 0);
    check("abort_adr", {16'b0, adr}, 0);
    check("abort_dat", dat_o, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, base_done);
    run(16'h0408, 16'h0580, 14'd2, 1'b0, 32'h0, 0, lat, b1, s1, a1);
    check("rerun_latency", lat, 13);
    check("rerun_m0", mem[16'h0580 >> 2], 32'hB0000002);
    check("rerun_m1", mem[16'h0584 >> 2], 32'hB0000003);

`ifdef AEMB_DMA_FILL_EN
    base_rd = rd_q.size();
    base_wr = wr_cnt;
    run(16'h0100, 16'h0300, 14'd3, 1'b1, 32'hDEADBEEF, 3, lat, b1, s1, a1);
    check("fill_latency", lat, 10);
    check("fill_nrd", rd_q.size() - base_rd, 0);
    check("fill_nwr", wr_cnt - base_wr, 3);
    check("fill_m0", mem[16'h0300 >> 2], 32'hDEADBEEF);
    check("fill_m1", mem[16'h0304 >> 2], 32'hDEADBEEF);
    check("fill_m2", mem[16'h0308 >> 2], 32'hDEADBEEF);
    check("fill_ignored_start", mem[16'h0A00 >> 2], 32'h5A5A5A5A);
`endif

    check("sel_violations", sel_err, 0);
    check("stb_adr_stability", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aemb_wb_dma.md
# aemb_wb_dma

Word-granularity Wishbone initiator that copies a block of 32-bit words from a source address to a destination address on the aeMB data bus. It drives the same `dwb_*` signal set that `aeMB_core` drives and sits as a second bus master, behind an arbiter, or directly on a simulation RAM. The block is a simple descriptor engine: load source, destination and length, pulse start, wait for `done_o`.

## Interface
- `DSIZ`, default 16: data-bus address width in bits (byte address).
- `sys_clk_i`  in  1  clock; all logic is on the rising edge.
- `sys_rst_i`  in  1  synchronous, active-high reset.
- `cfg_start_i`  in  1  one-cycle start strobe; ignored while `busy_o`=1.
- `cfg_src_i`  in  DSIZ  source byte address; bits [1:0] ignored (forced 0).
- `cfg_dst_i`  in  DSIZ  destination byte address; bits [1:0] ignored.
- `cfg_len_i`  in  DSIZ-2  word count.
- `cfg_fill_i`  in  1  fill-mode select (only with `AEMB_DMA_FILL_EN`).
- `cfg_pat_i`  in  32  fill pattern (only with `AEMB_DMA_FILL_EN`).
- `dwb_adr_o`  out  DSIZ  bus byte address; always word-aligned.
- `dwb_dat_o`  out  32  write data.
- `dwb_dat_i`  in  32  read data.
- `dwb_we_o`  out  1  1 = write cycle.
- `dwb_stb_o`  out  1  cycle strobe.
- `dwb_sel_o`  out  4  byte lanes; 4'hF during every cycle, 4'h0 when idle.
- `dwb_ack_i`  in  1  slave acknowledge.
- `busy_o`  out  1  transfer in progress.
- `done_o`  out  1  one-cycle pulse on completion.

## Operation
- FSM states: IDLE, RD, RGAP, WR, WGAP.
- IDLE + `cfg_start_i`: latch src, dst and len (low address bits cleared), set `busy_o`.
  - len≠0: go to RD.
  - len=0: pulse `done_o` next cycle, clear `busy_o`, no bus cycle.
- RD: `stb`=1, `we`=0, `adr`=src. On the edge where `dwb_ack_i`=1: latch `dwb_dat_i` into the data register, then go to RGAP.
- RGAP: `stb`=0 for exactly one cycle, then go to WR.
- WR: `stb`=1, `we`=1, `adr`=dst, `dat_o`=data register. On ack: src+=4, dst+=4, len-=1, then go to WGAP.
- WGAP: `stb`=0 for one cycle. Then go to RD if len≠0. Otherwise go to IDLE, clear `busy_o` and pulse `done_o`.
- `dwb_ack_i` is ignored outside RD and WR. This covers the stale ack that registered-ack slaves drive in the gap cycle.
- Address arithmetic is modulo 2^DSIZ. Incrementing past the top wraps to 0 silently.
- Data passes through unmodified. The block does no byte swapping.
- While the block is busy, any change on the `cfg_*` inputs has no effect.
- Reset mid-transfer: the next edge forces IDLE and clears all outputs. The aborted transfer produces no `done_o` pulse.

## Timing
- Reset values of all outputs are 0: `stb`, `we`, `sel`, `adr`, `dat_o`, `busy_o`, `done_o`.
- `busy_o` rises in the cycle after `cfg_start_i`. The first `stb` rises in that same cycle.
- `stb` holds until ack is sampled high and falls in the cycle after the ack edge.
- With a slave whose ack is a registered copy of `stb`, each phase takes 3 cycles, so copy mode costs 6 cycles per word.
- `done_o` rises in the cycle after the last WGAP.
- A start for an N-word copy to a zero-wait slave therefore gives `done_o` 6N+1 cycles after the start cycle.
- The slave may insert wait states freely. The block adds no timeout.

## Configuration
- `AEMB_DMA_FILL_EN` defined: `cfg_fill_i` is latched at start.
  - fill=1 skips RD and RGAP. Each word is a WR of the latched `cfg_pat_i` to dst, followed by WGAP, so the cost is 3 cycles per word. src is unused.
  - fill=0 behaves as plain copy.
- `AEMB_DMA_FILL_EN` undefined: `cfg_fill_i` and `cfg_pat_i` are unconnected. Every transfer is a copy, and no pattern register is synthesized.

## Structure
- Shared package `aemb_dma_pkg`: FSM state encoding and `SEL_WORD`=4'hF.
- One natural sub-module, `aemb_dma_cnt`: the src, dst and len registers with increment, decrement and zero detect.
- The FSM and the bus drive stay in the top-level module.

## Test plan
- Copy, registered-ack RAM: src=0x0100, dst=0x0200, len=4, words 0x11111111..0x44444444. Required response:
  - RAM[0x200..0x20C] equal the source words.
  - `sel`=F on every cycle.
  - `done_o` arrives 25 cycles after start.
- len=0: no `stb` at any time, and a single `done_o` pulse on the cycle after start.
- Wrap-around with DSIZ=16: src=0xFFF8, len=4. Required response: reads at 0xFFF8, 0xFFFC, 0x0000, 0x0004.
- Wait-state slave: ack delayed 3 cycles. Required response:
  - `stb` and `adr` stay stable until ack.
  - The stale gap-cycle ack does not advance the FSM.
  - Data is correct.
- Reset during the 2nd WR of a len=5 copy. Required response:
  - All outputs are 0 on the next edge, with no `done_o`.
  - A new start after reset runs to completion.
- `AEMB_DMA_FILL_EN` defined, fill=1, pat=0xDEADBEEF, dst=0x0300, len=3. Required response:
  - Three writes of 0xDEADBEEF and no read cycles.
  - `done_o` arrives 10 cycles after start.
  - Start pulses issued while busy are ignored.
